// File: rtl/hs_pkg.sv
// hs_pkg
// Shared definitions for the four-phase req/ack handshake blocks. It holds
// the destination FSM state encoding and the default sizing constants used
// by both sides of the crossing.
package hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_LOW = 2'd2
  } hs_state_t;

  localparam int HS_WIDTH       = 8;
  localparam int HS_FRAME_LEN   = 16;
  localparam int HS_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ndff.sv
// sync_ndff
// N-stage flip-flop synchronizer for a single asynchronous level signal.
// All stages reset to 0. The destination uses it for sreq and the source
// uses it for dack.
//
// Ports:
//   clk    in   destination-domain clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input level
//   q      out  synchronized level, STAGES clk edges behind d
module sync_ndff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/handshake_dest_ctrl.sv
// handshake_dest_ctrl
// Destination-side responder of the four-phase req/ack handshake. It
// synchronizes sreq, captures sdata, hands each word to the local consumer
// as a one-cycle dvalid pulse (stalling while busy) and answers with dack.
// It also counts words per frame and flags the last word of each frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transfer; waiting for the synchronized request
// HOLD     | word captured; waiting for the consumer to be not busy
// WAIT_LOW | word delivered, dack high; waiting for the request to drop
//
// Ports:
//   clk         in   destination clock, the only clock of the block
//   rst_n       in   asynchronous active-low reset
//   sreq        in   request from the source domain (asynchronous)
//   sdata       in   source word, stable while sreq is high until dack seen
//   busy        in   consumer cannot accept a word this cycle
//   dack        out  registered acknowledge to the source
//   dvalid      out  registered one-cycle word-valid pulse
//   dout        out  registered delivered word, 0 when dvalid is 0
//   frame_done  out  high with dvalid on the last word of a frame
//   dest_idle   out  FSM idle and no synchronized request pending
module handshake_dest_ctrl
  import hs_pkg::*;
#(
  parameter int WIDTH       = HS_WIDTH,
  parameter int SYNC_STAGES = HS_SYNC_STAGES,
  parameter int FRAME_LEN   = HS_FRAME_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sreq,
  input  logic [WIDTH-1:0] sdata,
  input  logic             busy,
  output logic             dack,
  output logic             dvalid,
  output logic [WIDTH-1:0] dout,
  output logic             frame_done,
  output logic             dest_idle
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             req_s;
  hs_state_t        state, state_nxt;
  logic [WIDTH-1:0] data_reg, data_nxt;
  logic [CNT_W-1:0] frame_cnt, cnt_nxt;
  logic             dack_nxt, dvalid_nxt, fd_nxt;
  logic [WIDTH-1:0] dout_nxt;

  sync_ndff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sreq),
    .q     (req_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      data_reg   <= '0;
      frame_cnt  <= '0;
      dack       <= 1'b0;
      dvalid     <= 1'b0;
      dout       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_reg   <= data_nxt;
      frame_cnt  <= cnt_nxt;
      dack       <= dack_nxt;
      dvalid     <= dvalid_nxt;
      dout       <= dout_nxt;
      frame_done <= fd_nxt;
    end
  end

  // dvalid, dout and frame_done default to 0 so they form single-cycle
  // pulses; dack is a level that only the handshake edges move.
  always_comb begin
    state_nxt  = state;
    data_nxt   = data_reg;
    cnt_nxt    = frame_cnt;
    dack_nxt   = dack;
    dvalid_nxt = 1'b0;
    dout_nxt   = '0;
    fd_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        dack_nxt = 1'b0;
        if (req_s) begin
          data_nxt  = sdata;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        dack_nxt = 1'b0;
        if (!busy) begin
          dvalid_nxt = 1'b1;
          dout_nxt   = data_reg;
          dack_nxt   = 1'b1;
          fd_nxt     = (frame_cnt == CNT_LAST);
          // FRAME_LEN is a power of two, so the wrap is the natural overflow.
          cnt_nxt    = frame_cnt + CNT_ONE;
          state_nxt  = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!req_s) begin
          dack_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          dack_nxt = 1'b1;
        end
      end
      default: begin
        dack_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign dest_idle = (state == ST_IDLE) && !req_s;

endmodule

// File: tb/tb_handshake_dest_ctrl.sv
// Testbench for handshake_dest_ctrl: acts as a four-phase source and a
// consumer with random back-pressure, predicting every output per cycle
// from the handshake timing rules and a running word counter.
module tb_handshake_dest_ctrl;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int FL = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sreq;
  logic [W-1:0] sdata;
  logic         busy;
  logic         dack;
  logic         dvalid;
  logic [W-1:0] dout;
  logic         frame_done;
  logic         dest_idle;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_words;

  always #5 clk = ~clk;

  handshake_dest_ctrl #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .FRAME_LEN   (FL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sreq       (sreq),
    .sdata      (sdata),
    .busy       (busy),
    .dack       (dack),
    .dvalid     (dvalid),
    .dout       (dout),
    .frame_done (frame_done),
    .dest_idle  (dest_idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a falling edge; leaves the bench just after one.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_dack",       32'(dack),       32'd0);
    chk("rst_dvalid",     32'(dvalid),     32'd0);
    chk("rst_dout",       32'(dout),       32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_dest_idle",  32'(dest_idle),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_words = 0;
  endtask

  // One four-phase transfer. stall < 0 selects random busy; otherwise busy
  // is held high for exactly 'stall' cycles after the capture edge.
  task automatic xfer(input logic [W-1:0] d, input int stall, input int hold,
                      input bit chg_ff, input bit rst_after);
    int  k;
    bit  done;
    logic b;
    sdata = d;
    sreq  = 1'b1;
    k     = 0;
    done  = 1'b0;
    // Edge k=0 is the first edge to sample sreq high; capture happens at
    // edge S, delivery at the first later edge that samples busy low.
    while (!done) begin
      if (stall < 0) b = (k > S + 20) ? 1'b0 : 1'($urandom_range(0, 1));
      else           b = (k > S) && (k <= S + stall);
      busy = b;
      @(posedge clk);
      @(negedge clk);
      if (k > S && !b) begin
        chk("dvalid_deliver", 32'(dvalid),     32'd1);
        chk("dout_deliver",   32'(dout),       32'(d));
        chk("dack_rise",      32'(dack),       32'd1);
        chk("frame_done",     32'(frame_done), 32'((exp_words % FL) == FL - 1));
        chk("idle_deliver",   32'(dest_idle),  32'd0);
        exp_words++;
        done = 1'b1;
      end else begin
        chk("dvalid_quiet", 32'(dvalid),     32'd0);
        chk("dack_low",     32'(dack),       32'd0);
        chk("dout_zero",    32'(dout),       32'd0);
        chk("fd_quiet",     32'(frame_done), 32'd0);
        chk("idle_rise",    32'(dest_idle),  32'(k < S - 1));
      end
      k++;
    end
    if (rst_after) begin
      sdata = ~d;
      do_reset();
      return;
    end
    // Source has now seen dack, so sdata may change freely.
    sdata = chg_ff ? 8'hFF : 8'($urandom);
    for (int h = 0; h < hold; h++) begin
      busy = (stall < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("dvalid_hold", 32'(dvalid),    32'd0);
      chk("dout_hold",   32'(dout),      32'd0);
      chk("dack_hold",   32'(dack),      32'd1);
      chk("idle_hold",   32'(dest_idle), 32'd0);
    end
    sreq = 1'b0;
    for (int f = 0; f <= S; f++) begin
      busy = (stall < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("dvalid_fall", 32'(dvalid),    32'd0);
      chk("dack_fall",   32'(dack),      32'(f < S));
      chk("idle_fall",   32'(dest_idle), 32'(f >= S));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sreq  = 1'b0;
    busy  = 1'b0;
    sdata = '0;
    exp_words = 0;
    @(negedge clk);
    do_reset();

    // single word
    xfer(8'hA3, 0, 0, 1'b0, 1'b0);
    // busy stall of five cycles
    xfer(8'h5C, 5, 1, 1'b0, 1'b0);
    // data change after dack, no second delivery
    xfer(8'h3C, 0, 3, 1'b1, 1'b0);
    // reset in WAIT_LOW, then sreq still high gives one new delivery
    xfer(8'h77, 0, 0, 1'b0, 1'b1);
    xfer(8'h88, 0, 1, 1'b0, 1'b0);

    // frame wrap from a clean counter
    do_reset();
    for (int i = 0; i < FL + 1; i++) begin
      xfer(8'(i), -1, $urandom_range(0, 2), 1'b0, 1'b0);
    end

    // random traffic
    for (int i = 0; i < 24; i++) begin
      xfer(8'($urandom), -1, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/handshake_dest_ctrl.md
# handshake_dest_ctrl

Destination-side responder of the four-phase req/ack handshake that carries matrix words from the CLK1 domain into the CLK2 domain. It runs entirely on the CLK2 clock and synchronizes the asynchronous `sreq`. It captures `sdata`, delivers each word to the CLK2 consumer as a one-cycle `dvalid` pulse, stalling while the consumer reports `busy`, and answers with `dack`. It also counts words per frame and flags the last word of each frame.

## Interface
- `WIDTH`, 8, data word width (`{A,B}` nibble pair)
- `SYNC_STAGES`, 2, flip-flop stages on the `sreq` synchronizer (≥2)
- `FRAME_LEN`, 16, words per frame; a power of two
- `clk`  in  1  CLK2-domain clock; the only clock in the block
- `rst_n`  in  1  reset, asynchronous, active-low
- `sreq`  in  1  request from the source domain, asynchronous to `clk`
- `sdata`  in  WIDTH  source data; stable from `sreq` rise until `dack` is observed high
- `busy`  in  1  consumer cannot accept a word this cycle
- `dack`  out  1  acknowledge to the source domain, registered
- `dvalid`  out  1  one-cycle word-valid pulse to the consumer, registered
- `dout`  out  WIDTH  delivered word, registered; 0 when `dvalid`=0
- `frame_done`  out  1  high together with `dvalid` on the last word of a frame
- `dest_idle`  out  1  high when state is IDLE and the synchronized `sreq` (`req_s`) is 0

## Operation
- `req_s` is the output of a SYNC_STAGES-deep flip-flop chain clocked by `clk` and reset to 0.
- **IDLE**
  - `req_s`=1: latch `sdata` into `data_reg`, go to HOLD.
  - Otherwise stay in IDLE.
- **HOLD**
  - `busy`=0: register `dvalid`<=1, `dout`<=`data_reg`, `dack`<=1, go to WAIT_LOW.
  - `busy`=1: stay in HOLD with `dvalid`=0 and `dack`=0, so the source stalls. There is no timeout.
- **WAIT_LOW**
  - `dvalid`<=0 and `dout`<=0 every cycle.
  - `req_s`=0: `dack`<=0, go to IDLE.
  - Otherwise stay, holding `dack`=1.
- `frame_cnt` is $clog2(FRAME_LEN) bits wide.
  - Increments on every delivered word.
  - Wraps from FRAME_LEN-1 to 0.
  - `frame_done` is registered alongside `dvalid`: 1 exactly when the word being delivered is delivered while `frame_cnt`==FRAME_LEN-1.
- `sdata` is sampled only in IDLE, after `req_s`=1. The source guarantees it has been stable since before the `sreq` rise, so no data synchronizer is needed.
- A new request is never accepted until `dack` has returned to 0 and the state is back in IDLE.
- **Reset**
  - Every flip-flop clears: state IDLE; `dack`, `dvalid`, `dout`, `frame_done`, `frame_cnt`, `data_reg` and the synchronizer chain all 0.
  - `dest_idle` is 1 once `req_s` is 0.
  - Reset mid-transfer discards the captured word.
  - An `sreq` still high after reset is treated as a new request.

## Timing
- `sreq` rising before clock edge E0 → `req_s`=1 after edge E0+SYNC_STAGES-1 → capture at E0+SYNC_STAGES → `dvalid`/`dack` high after E0+SYNC_STAGES+1, provided `busy`=0 at that edge.
- Each cycle of `busy`=1 in HOLD adds exactly one cycle to the latency.
- `dvalid` is high for exactly one cycle per word and is never asserted on consecutive cycles. There is a minimum of SYNC_STAGES+3 cycles between pulses, bounded by the four-phase return-to-zero.
- `dack` falls one edge after `req_s` is sampled 0 in WAIT_LOW.
- `busy` only matters in HOLD; its value is ignored in IDLE and WAIT_LOW.
- Simultaneous `req_s` fall and `busy` change in WAIT_LOW: `busy` is ignored and `dack` falls normally.

## Structure
- Shared package (`hs_pkg`): state encoding (IDLE=0, HOLD=1, WAIT_LOW=2) and default constants WIDTH=8, FRAME_LEN=16.
- One sub-module, `sync_ndff`: a parameterized N-stage, reset-to-0, single-bit synchronizer used for `sreq`. The source side reuses it for `dack`.
- Target size: about 150 RTL lines including the synchronizer.

## Test plan
- **Single word.** After reset, `sdata`=8'hA3, `sreq`=1, `busy`=0 → `dvalid`=1 and `dout`=8'hA3 exactly 3 edges after the first edge that samples `sreq` high. `dack` rises on that same edge. Dropping `sreq` → `dack`=0 three edges later and `dest_idle`=1.
- **Busy stall.** Hold `busy`=1 for 5 cycles while in HOLD → no `dvalid`, `dack` stays 0. `dvalid` appears on the edge after `busy` falls and `dout` is unchanged.
- **Frame wrap.** 16 back-to-back four-phase transfers with data 8'h00..8'h0F → `frame_done`=1 only alongside `dout`=8'h0F. On the 17th word, `frame_cnt` has wrapped and `frame_done`=0.
- **Reset mid-operation.** Assert `rst_n`=0 while in WAIT_LOW with `dack`=1 → `dack`, `dvalid` and `dout` go 0 immediately. Releasing reset with `sreq`=1 produces one new delivery of the current `sdata`.
- **Data stability.** Change `sdata` to 8'hFF after `dack` rises, while `sreq` is still high → the already-delivered `dout` value stays the original word, and no second `dvalid` is produced.
